// File: rtl/mac_sequencer_pkg.sv
// Shared widths and sequencer state encoding for the MAC-lane sequencer.
package mac_sequencer_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_HOLD  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of the sequencer's command, operand-stream, MAC-side and result signals.
interface mac_sequencer_if #(
   parameter int LEN_W = 8
);
   import mac_sequencer_pkg::*;

   // Both streams use strict valid/ready: a transfer happens on a rising edge where
   // VALID and READY are both 1; VALID never depends on READY, and the producer holds
   // its payload stable while VALID is 1 without READY.
   logic              START;
   logic [LEN_W-1:0]  LEN;
   logic [ACC_W-1:0]  BIAS;
   logic              BUSY;
   logic              IN_VALID;
   logic              IN_READY;
   logic [DATA_W-1:0] IN_A;
   logic [DATA_W-1:0] IN_B;
   logic              EN_MAC;
   logic              RST_MAC;
   logic [ACC_W-1:0]  BIAS_IN;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [ACC_W-1:0]  MAC_Y;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [ACC_W-1:0]  OUT_Y;
   seq_state_e        STATE_DBG;

   modport slave (
      input  START, LEN, BIAS, IN_VALID, IN_A, IN_B, MAC_Y, OUT_READY,
      output BUSY, IN_READY, EN_MAC, RST_MAC, BIAS_IN, A, B, OUT_VALID, OUT_Y, STATE_DBG
   );

   modport master (
      output START, LEN, BIAS, IN_VALID, IN_A, IN_B, MAC_Y, OUT_READY,
      input  BUSY, IN_READY, EN_MAC, RST_MAC, BIAS_IN, A, B, OUT_VALID, OUT_Y, STATE_DBG
   );

endinterface

// File: rtl/mac_sequencer.sv
// Drives one MAC lane through a biased dot product of LEN int8 pairs and
// returns the captured accumulator on a valid/ready result port.
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input logic            CLKEXT,
   input logic            RSTEXT,
   mac_sequencer_if.slave bus
);

   seq_state_e       state;
   logic [LEN_W-1:0] cnt;
   logic [ACC_W-1:0] bias_q;
   logic [ACC_W-1:0] out_y_q;
   logic             out_valid_q;
   logic             in_hs;
   logic             out_hs;

   assign in_hs  = (state == ST_RUN) && bus.IN_VALID;
   assign out_hs = (state == ST_HOLD) && out_valid_q && bus.OUT_READY;

   always_ff @(posedge CLKEXT or posedge RSTEXT) begin
      if (RSTEXT) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bias_q      <= '0;
         out_y_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.START) begin
                  cnt    <= bus.LEN;
                  bias_q <= bus.BIAS;
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= (cnt == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
               if (in_hs) begin
                  cnt <= cnt - LEN_W'(1);
                  if (cnt == LEN_W'(1)) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // MAC_Y already reflects the last enabled edge here.
               out_y_q     <= bus.MAC_Y;
               out_valid_q <= 1'b1;
               state       <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_hs) begin
                  out_valid_q <= 1'b0;
                  // A START in the release cycle is taken as if IDLE, saving a cycle.
                  if (bus.START) begin
                     cnt    <= bus.LEN;
                     bias_q <= bus.BIAS;
                     state  <= ST_LOAD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.BUSY      = (state != ST_IDLE);
   assign bus.IN_READY  = (state == ST_RUN);
   assign bus.EN_MAC    = (state == ST_LOAD) || in_hs;
   assign bus.RST_MAC   = (state == ST_LOAD);
   assign bus.A         = in_hs ? bus.IN_A : '0;
   assign bus.B         = in_hs ? bus.IN_B : '0;
   assign bus.BIAS_IN   = bias_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.OUT_Y     = out_y_q;
   assign bus.STATE_DBG = state;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a saturating MAC stand-in, directed table vectors,
// hand-written reset/back-to-back sequences and randomized operations.
module tb_mac_sequencer;
   import mac_sequencer_pkg::*;

   // ---------------- clock / reset ----------------
   logic CLKEXT = 1'b0;
   logic RSTEXT = 1'b0;
   always #5 CLKEXT = ~CLKEXT;

   mac_sequencer_if #(.LEN_W(8)) bus ();

   mac_sequencer #(.LEN_W(8)) dut (
      .CLKEXT (CLKEXT),
      .RSTEXT (RSTEXT),
      .bus    (bus)
   );

   // ---------------- MAC lane stand-in ----------------
   logic signed [15:0] mac_acc = 16'sd0;

   function automatic logic signed [15:0] sat16(input int v);
      if (v > 32767) return 16'sh7fff;
      if (v < -32768) return 16'sh8000;
      return 16'(v);
   endfunction

   always @(posedge CLKEXT) begin
      if (bus.EN_MAC) begin
         if (bus.RST_MAC) mac_acc <= $signed(bus.BIAS_IN);
         else mac_acc <= sat16(int'(mac_acc) + int'($signed(bus.A)) * int'($signed(bus.B)));
      end
   end
   assign bus.MAC_Y = mac_acc;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];
   logic signed [7:0] pa[256];
   logic signed [7:0] pb[256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: bias plus each product, clamped to int16 after every accumulate.
   function automatic logic [15:0] ref_dot(input int len, input logic [15:0] bias);
      int acc;
      acc = int'($signed(bias));
      for (int i = 0; i < len; i++) begin
         acc = acc + int'(pa[i]) * int'(pb[i]);
         if (acc > 32767) acc = 32767;
         if (acc < -32768) acc = -32768;
      end
      return 16'(acc);
   endfunction

   // Whenever the MAC is not enabled its operand and select lines must be quiet.
   always @(negedge CLKEXT) begin
      if (!RSTEXT && !bus.EN_MAC)
         check("gate_ab_rst", 32'({bus.A, bus.B, bus.RST_MAC}), 32'd0);
   end

   // ---------------- driver ----------------
   // mode: 0 = IN_VALID always, 1 = alternate cycles, 2 = random bubbles.
   task automatic do_op(input int len, input logic [15:0] bias, input int mode,
                        input int rdelay, input bit noise, input bit skip_start,
                        input bit chain, input int nlen, input logic [15:0] nbias,
                        input bit use_tab, input logic [15:0] tab_y, input int tab_lat);
      int c, idx, bubbles, v, exp_lat;
      bit seen, hs, ohs, done;
      exp_q.push_back(use_tab ? tab_y : ref_dot(len, bias));
      c = skip_start ? 1 : 0;
      idx = 0; bubbles = 0; v = 0; seen = 0; done = 0;
      while (!done) begin
         bus.START = (c == 0);
         if (c == 0) begin
            bus.LEN  = 8'(len);
            bus.BIAS = bias;
         end
         bus.IN_VALID = 1'b0;
         if (idx < len) begin
            case (mode)
               0:       bus.IN_VALID = 1'b1;
               1:       bus.IN_VALID = (c % 2 == 1);
               default: bus.IN_VALID = ($urandom_range(0, 3) != 0);
            endcase
         end
         bus.IN_A = bus.IN_VALID ? pa[idx] : 8'($urandom);
         bus.IN_B = bus.IN_VALID ? pb[idx] : 8'($urandom);
         bus.OUT_READY = (rdelay == 0) || (seen && c >= v + rdelay);
         if (noise && bus.OUT_VALID && !bus.OUT_READY) begin
            bus.START = 1'($urandom_range(0, 1));
            bus.LEN   = 8'($urandom);
            bus.BIAS  = 16'($urandom);
         end
         if (chain && bus.OUT_VALID && bus.OUT_READY) begin
            bus.START = 1'b1;
            bus.LEN   = 8'(nlen);
            bus.BIAS  = nbias;
         end
         @(negedge CLKEXT);
         if (c == 1) begin
            check("load_state", 32'(bus.STATE_DBG), 32'(ST_LOAD));
            check("load_en_rst", 32'({bus.EN_MAC, bus.RST_MAC}), 32'd3);
         end
         if (c >= 1) check("bias_in", 32'(bus.BIAS_IN), 32'(bias));
         if (c >= 2 && idx < len && !bus.IN_VALID) bubbles++;
         hs  = bus.IN_VALID && bus.IN_READY;
         ohs = bus.OUT_VALID && bus.OUT_READY;
         if (bus.OUT_VALID) begin
            if (!seen) begin
               seen = 1;
               v = c;
            end
            check("out_y", 32'(bus.OUT_Y), 32'(exp_q[0]));
         end
         @(posedge CLKEXT);
         #1;
         if (hs) idx++;
         if (ohs) begin
            void'(exp_q.pop_front());
            done = 1;
         end else if (c > 600) begin
            check("timeout", 32'd1, 32'd0);
            void'(exp_q.pop_front());
            done = 1;
         end
         c++;
      end
      exp_lat = (tab_lat >= 0) ? tab_lat : len + 3 + bubbles;
      check("latency", 32'(v), 32'(exp_lat));
      check("pairs_used", 32'(idx), 32'(len));
      bus.START = 1'b0;
      bus.IN_VALID = 1'b0;
      bus.OUT_READY = 1'b0;
      if (!chain) begin
         @(negedge CLKEXT);
         check("idle_after", 32'({bus.BUSY, bus.OUT_VALID}), 32'd0);
         check("idle_state", 32'(bus.STATE_DBG), 32'(ST_IDLE));
         @(posedge CLKEXT);
         #1;
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int          len;
      logic [15:0] bias;
      int          a[4];
      int          b[4];
      int          mode;
      int          rdelay;
      bit          noise;
      logic [15:0] exp_y;
      int          exp_lat;
   } vec_t;

   vec_t vecs[4];

   initial begin : main
      int len, nlen, rdelay;
      logic [15:0] bias, nbias;
      bit chained, do_chain, noise;

      vecs[0] = '{3, 16'd10,    '{2, -4, 7, 0},   '{3, 5, 7, 0},    0, 0, 0, 16'd45,   6};
      vecs[1] = '{0, 16'hFFFB,  '{0, 0, 0, 0},    '{0, 0, 0, 0},    0, 0, 0, 16'hFFFB, 3};
      vecs[2] = '{3, 16'd10,    '{2, -4, 7, 0},   '{3, 5, 7, 0},    1, 0, 0, 16'd45,   9};
      vecs[3] = '{2, 16'd32000, '{127, 127, 0, 0}, '{127, 127, 0, 0}, 0, 5, 1, 16'h7FFF, 5};

      bus.START = 0; bus.LEN = 0; bus.BIAS = 0; bus.IN_VALID = 0;
      bus.IN_A = 0; bus.IN_B = 0; bus.OUT_READY = 0;

      #1 RSTEXT = 1'b1;
      #2;
      check("rst_busy_rdy", 32'({bus.BUSY, bus.IN_READY}), 32'd0);
      check("rst_en_rst", 32'({bus.EN_MAC, bus.RST_MAC}), 32'd0);
      check("rst_ab", 32'({bus.A, bus.B}), 32'd0);
      check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("rst_out_y", 32'(bus.OUT_Y), 32'd0);
      check("rst_bias_in", 32'(bus.BIAS_IN), 32'd0);
      check("rst_state", 32'(bus.STATE_DBG), 32'(ST_IDLE));
      repeat (2) @(posedge CLKEXT);
      @(negedge CLKEXT) RSTEXT = 1'b0;
      @(posedge CLKEXT);
      #1;

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            pa[j] = 8'(vecs[i].a[j]);
            pb[j] = 8'(vecs[i].b[j]);
         end
         do_op(vecs[i].len, vecs[i].bias, vecs[i].mode, vecs[i].rdelay, vecs[i].noise,
               0, 0, 0, 16'd0, 1, vecs[i].exp_y, vecs[i].exp_lat);
      end

      // Reset in the middle of a LEN=4 run after two accepted pairs.
      bus.START = 1; bus.LEN = 8'd4; bus.BIAS = 16'd50;
      bus.IN_VALID = 1; bus.IN_A = 8'd1; bus.IN_B = 8'd1; bus.OUT_READY = 1;
      @(posedge CLKEXT); #1 bus.START = 0;
      repeat (3) begin
         @(posedge CLKEXT);
         #1;
      end
      check("pre_reset_run", 32'(bus.STATE_DBG), 32'(ST_RUN));
      #2 RSTEXT = 1'b1;
      #1;
      check("midrst_busy_rdy", 32'({bus.BUSY, bus.IN_READY}), 32'd0);
      check("midrst_out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("midrst_en", 32'(bus.EN_MAC), 32'd0);
      bus.IN_VALID = 0; bus.OUT_READY = 0;
      @(negedge CLKEXT) RSTEXT = 1'b0;
      @(posedge CLKEXT);
      #1;
      pa[0] = 8'sd3; pb[0] = -8'sd3;
      do_op(1, 16'd0, 0, 0, 0, 0, 0, 0, 16'd0, 1, 16'hFFF7, 4);

      // START in the result handshake cycle goes straight to LOAD with the new bias.
      do_op(0, 16'd7, 0, 0, 0, 0, 1, 1, 16'd100, 1, 16'd7, 3);
      pa[0] = 8'sd2; pb[0] = 8'sd3;
      do_op(1, 16'd100, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'd106, 4);

      // Randomized operations against the reference model.
      chained = 0; nlen = 0; nbias = 0;
      for (int it = 0; it < 24; it++) begin
         len  = chained ? nlen : int'($urandom_range(0, 12));
         bias = chained ? nbias : 16'($urandom);
         for (int j = 0; j < len; j++) begin
            pa[j] = 8'($urandom);
            pb[j] = 8'($urandom);
         end
         rdelay   = int'($urandom_range(0, 3));
         noise    = 1'($urandom_range(0, 1));
         do_chain = (it < 23) && ($urandom_range(0, 2) == 0);
         nlen     = int'($urandom_range(0, 12));
         nbias    = 16'($urandom);
         do_op(len, bias, 2, rdelay, noise, chained, do_chain, nlen, nbias, 0, 16'd0, -1);
         chained = do_chain;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
